// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_if
// Brief    : Bundle of cpu, DMA, init and data-memory signals around the arbiter
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if;
  logic        init_start;
  logic        init_busy;
  logic        init_done;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_ack;
  logic [31:0] dma_rdata;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata;
  logic        addr_err;

  modport slave (
    input  init_start, cpu_req, cpu_we, cpu_addr, cpu_wdata,
           dma_req, dma_we, dma_addr, dma_wdata, mem_rdata,
    output init_busy, init_done, cpu_rdata, cpu_stall, dma_ack, dma_rdata,
           mem_address, mem_write_data, mem_write, mem_read, addr_err
  );

  modport master (
    output init_start, cpu_req, cpu_we, cpu_addr, cpu_wdata,
           dma_req, dma_we, dma_addr, dma_wdata, mem_rdata,
    input  init_busy, init_done, cpu_rdata, cpu_stall, dma_ack, dma_rdata,
           mem_address, mem_write_data, mem_write, mem_read, addr_err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Init-fill sequencer plus cpu/DMA arbiter for a single-port dmem
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int          MEM_BYTES    = 256,
  parameter int          INIT_WORDS   = 10,
  parameter logic [31:0] INIT_VALUE   = 32'd5,
  parameter int          STARVE_LIMIT = 4
) (
  input  wire logic   clk,
  input  wire logic   reset,
  dmem_arbiter_if.slave bus
);

  localparam int          c_CNT_W    = $clog2(INIT_WORDS + 1);
  localparam int          c_ST_W     = $clog2(STARVE_LIMIT + 1);
  localparam logic [31:0] c_MAX_ADDR = 32'(MEM_BYTES - 4);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_INIT = 1'b1
  } state_t;

  state_t              r_state;
  logic [c_CNT_W-1:0]  r_init_cnt;
  logic [c_ST_W-1:0]   r_starve;
  logic                r_init_prev;
  logic                r_init_done;
  logic                r_dma_ack;
  logic [31:0]         r_dma_rdata;
  logic                r_addr_err;

  logic                w_idle;
  logic                w_init;
  logic                w_init_rise;
  logic                w_dma_ok;
  logic                w_starved;
  logic                w_grant_dma;
  logic                w_grant_cpu;
  logic                w_sel_we;
  logic [31:0]         w_sel_addr;
  logic [31:0]         w_sel_wdata;
  logic                w_illegal;
  logic                w_access;

  // Combinational outputs are forced quiet while reset is held.
  assign w_idle      = (r_state == ST_IDLE) && !reset;
  assign w_init      = (r_state == ST_INIT) && !reset;
  assign w_init_rise = bus.init_start && !r_init_prev;
  assign w_dma_ok    = bus.dma_req && !r_dma_ack;
  assign w_starved   = (r_starve == c_ST_W'(STARVE_LIMIT));
  assign w_grant_dma = w_idle && w_dma_ok && (w_starved || !bus.cpu_req);
  assign w_grant_cpu = w_idle && bus.cpu_req && !w_grant_dma;

  assign w_sel_we    = w_grant_dma ? bus.dma_we    : bus.cpu_we;
  assign w_sel_addr  = w_grant_dma ? bus.dma_addr  : bus.cpu_addr;
  assign w_sel_wdata = w_grant_dma ? bus.dma_wdata : bus.cpu_wdata;
  assign w_illegal   = (w_sel_addr[1:0] != 2'b00) || (w_sel_addr > c_MAX_ADDR);
  assign w_access    = (w_grant_cpu || w_grant_dma) && !w_illegal;

  always_comb begin
    bus.mem_write      = 1'b0;
    bus.mem_read       = 1'b0;
    bus.mem_address    = '0;
    bus.mem_write_data = '0;
    if (w_init) begin
      bus.mem_write      = 1'b1;
      bus.mem_address    = {{(30 - c_CNT_W){1'b0}}, r_init_cnt, 2'b00};
      bus.mem_write_data = INIT_VALUE;
    end else if (w_access) begin
      bus.mem_write   = w_sel_we;
      bus.mem_read    = !w_sel_we;
      bus.mem_address = w_sel_addr;
      if (w_sel_we) begin
        bus.mem_write_data = w_sel_wdata;
      end
    end
  end

  assign bus.cpu_stall = bus.cpu_req && !w_grant_cpu && !reset;
  assign bus.cpu_rdata = (w_grant_cpu && !w_illegal && !bus.cpu_we) ? bus.mem_rdata : '0;
  assign bus.init_busy = (r_state == ST_INIT);
  assign bus.init_done = r_init_done;
  assign bus.dma_ack   = r_dma_ack;
  assign bus.dma_rdata = r_dma_rdata;
  assign bus.addr_err  = r_addr_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_init_cnt  <= '0;
      r_starve    <= '0;
      r_init_prev <= 1'b0;
      r_init_done <= 1'b0;
      r_dma_ack   <= 1'b0;
      r_dma_rdata <= '0;
      r_addr_err  <= 1'b0;
    end else begin
      r_init_prev <= bus.init_start;
      r_init_done <= 1'b0;
      r_dma_ack   <= w_grant_dma;
      if (w_grant_dma) begin
        r_dma_rdata <= (w_illegal || w_sel_we) ? 32'd0 : bus.mem_rdata;
      end
      if ((w_grant_cpu || w_grant_dma) && w_illegal) begin
        r_addr_err <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_init_rise) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
          end
          if (w_grant_dma || !bus.dma_req) begin
            r_starve <= '0;
          end else if (w_grant_cpu && !w_starved) begin
            r_starve <= r_starve + 1'b1;
          end
        end
        ST_INIT: begin
          if (r_init_cnt == c_CNT_W'(INIT_WORDS - 1)) begin
            r_state     <= ST_IDLE;
            r_init_cnt  <= '0;
            r_init_done <= 1'b1;
          end else begin
            r_init_cnt <= r_init_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
